// File: rtl/arb16_pkg.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
package arb16_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned ID_W  = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_16_if.sv
// Requester-side bundle of the arbiter: request/enable/release in, grant status out.
interface rr_arbiter_16_if;
    import arb16_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    // "release" is a reserved word in SystemVerilog, hence "rel"
    logic             rel;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             busy;
    logic             timeout;

    modport master (
        output en, req, rel,
        input  grant, grant_id, busy, timeout
    );

    modport slave (
        input  en, req, rel,
        output grant, grant_id, busy, timeout
    );

endinterface

// File: rtl/four_to_sixteen.sv
// 4-to-16 one-hot decoder with enable; all outputs low when disabled.
module four_to_sixteen (
    input  logic [3:0]  sel,
    input  logic        en,
    output logic [15:0] dec
);

    always_comb begin
        dec = '0;
        if (en) begin
            dec[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_16_pick16.sv
// Combinational circular priority pick: first set request at or after ptr, wrapping at 16.
module rr_pick16
    import arb16_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  pick_id,
    output logic             pick_vld
);

    logic [ID_W-1:0] idx;

    always_comb begin
        pick_id  = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ptr + ID_W'(i);
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters: holds a grant until release, drop, enable loss or
// hold timeout, then forces one idle cycle and rotates priority past the last winner.
module rr_arbiter_16
    import arb16_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_16_if.slave bus
);

    localparam int unsigned CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

    arb_state_e      state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] grant_id_q;
    logic [CNT_W-1:0] hold_cnt;
    logic            timeout_q;
    logic            busy;

    logic [ID_W-1:0] pick_id;
    logic            pick_vld;

    logic rel_end;
    logic drop_end;
    logic en_end;
    logic hold_end;
    logic grant_end;
    logic hold_timeout;

    rr_pick16 u_pick (
        .req      (bus.req),
        .ptr      (ptr),
        .pick_id  (pick_id),
        .pick_vld (pick_vld)
    );

    assign busy = (state == GRANT);

    // Decoder enable includes en so the grant drops in the same cycle en falls.
    four_to_sixteen u_dec (
        .sel (grant_id_q),
        .en  (bus.en & busy),
        .dec (bus.grant)
    );

    assign rel_end      = bus.rel;
    assign drop_end     = !bus.req[grant_id_q];
    assign en_end       = !bus.en;
    assign hold_end     = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign grant_end    = rel_end | drop_end | en_end | hold_end;
    assign hold_timeout = hold_end & !rel_end & !drop_end & !en_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            grant_id_q <= '0;
            hold_cnt   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (bus.en && pick_vld) begin
                        state      <= GRANT;
                        grant_id_q <= pick_id;
                        ptr        <= pick_id + ID_W'(1);
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        state     <= IDLE;
                        hold_cnt  <= '0;
                        timeout_q <= hold_timeout;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed scoreboard bench for rr_arbiter_16 with a short hold limit (MAX_HOLD=4).
module tb_rr_arbiter_16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_arbiter_16_if bus_if ();

    rr_arbiter_16 #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] grant;
        logic [3:0]  id;
        logic        id_care;
        logic        busy;
        logic        timeout;
        int          step;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    task automatic check(input string name, input int step, input logic [31:0] act,
                         input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s step %0d actual=%0h required=%0h", name, step, act, req_v);
        end
    endtask

    // One cycle of stimulus: inputs applied just after the edge, expected outputs of that cycle queued.
    task automatic step(input logic r, input logic e, input logic [15:0] q, input logic rl,
                        input logic [15:0] g, input logic [3:0] id, input logic idc,
                        input logic b, input logic t);
        exp_t x;
        @(posedge clk);
        #1;
        rst        = r;
        bus_if.en  = e;
        bus_if.req = q;
        bus_if.rel = rl;
        step_no++;
        x.grant = g; x.id = id; x.id_care = idc; x.busy = b; x.timeout = t; x.step = step_no;
        sb.push_back(x);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("grant",   x.step, 32'(bus_if.grant),   32'(x.grant));
                check("busy",    x.step, 32'(bus_if.busy),    32'(x.busy));
                check("timeout", x.step, 32'(bus_if.timeout), 32'(x.timeout));
                if (x.id_care) check("grant_id", x.step, 32'(bus_if.grant_id), 32'(x.id));
                check("onehot0", x.step, 32'($onehot0(bus_if.grant)), 32'd1);
                if (bus_if.grant != '0)
                    check("grant_valid", x.step, 32'({bus_if.busy, bus_if.en}), 32'b11);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog step %0d actual=timeout required=finish", step_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.en  = 1'b1;
        bus_if.req = 16'hFFFF;
        bus_if.rel = 1'b0;

        // Reset held two cycles with all requests high
        step(1, 1, 16'hFFFF, 0, 16'h0000, 4'd0, 1, 0, 0);
        step(1, 1, 16'hFFFF, 0, 16'h0000, 4'd0, 1, 0, 0);
        step(0, 0, 16'h0000, 0, 16'h0000, 4'd0, 1, 0, 0);

        // Rotation between requesters 0 and 4
        step(0, 1, 16'h0011, 0, 16'h0000, 4'd0, 1, 0, 0);
        step(0, 1, 16'h0011, 0, 16'h0001, 4'd0, 1, 1, 0);
        step(0, 1, 16'h0011, 1, 16'h0001, 4'd0, 1, 1, 0);
        step(0, 1, 16'h0011, 0, 16'h0000, 4'd0, 1, 0, 0);
        step(0, 1, 16'h0011, 0, 16'h0010, 4'd4, 1, 1, 0);
        step(0, 1, 16'h0011, 1, 16'h0010, 4'd4, 1, 1, 0);
        step(0, 1, 16'h0011, 0, 16'h0000, 4'd4, 1, 0, 0);
        step(0, 1, 16'h0011, 0, 16'h0001, 4'd0, 1, 1, 0);
        step(0, 1, 16'h0011, 1, 16'h0001, 4'd0, 1, 1, 0);
        step(0, 1, 16'h0000, 0, 16'h0000, 4'd0, 1, 0, 0);

        // Wrap: grant 14 puts ptr at 15, then 15 before 0
        step(0, 1, 16'h4000, 0, 16'h0000, 4'd0, 1, 0, 0);
        step(0, 1, 16'h4000, 1, 16'h4000, 4'd14, 1, 1, 0);
        step(0, 1, 16'h8001, 0, 16'h0000, 4'd14, 1, 0, 0);
        step(0, 1, 16'h8001, 1, 16'h8000, 4'd15, 1, 1, 0);
        step(0, 1, 16'h8001, 0, 16'h0000, 4'd15, 1, 0, 0);
        step(0, 1, 16'h8001, 1, 16'h0001, 4'd0, 1, 1, 0);
        step(0, 1, 16'h0000, 0, 16'h0000, 4'd0, 1, 0, 0);

        // Hold timeout after four grant cycles
        step(0, 1, 16'h0008, 0, 16'h0000, 4'd0, 1, 0, 0);
        step(0, 1, 16'h0008, 0, 16'h0008, 4'd3, 1, 1, 0);
        step(0, 1, 16'h0008, 0, 16'h0008, 4'd3, 1, 1, 0);
        step(0, 1, 16'h0008, 0, 16'h0008, 4'd3, 1, 1, 0);
        step(0, 1, 16'h0008, 0, 16'h0008, 4'd3, 1, 1, 0);
        step(0, 1, 16'h0008, 0, 16'h0000, 4'd3, 1, 0, 1);

        // Release in the would-be timeout cycle suppresses the pulse
        step(0, 1, 16'h0008, 0, 16'h0008, 4'd3, 1, 1, 0);
        step(0, 1, 16'h0008, 0, 16'h0008, 4'd3, 1, 1, 0);
        step(0, 1, 16'h0008, 0, 16'h0008, 4'd3, 1, 1, 0);
        step(0, 1, 16'h0008, 1, 16'h0008, 4'd3, 1, 1, 0);
        step(0, 1, 16'h0000, 0, 16'h0000, 4'd3, 1, 0, 0);

        // Enable loss mid-grant, then requests ignored while disabled
        step(0, 1, 16'h0004, 0, 16'h0000, 4'd3, 1, 0, 0);
        step(0, 1, 16'h0004, 0, 16'h0004, 4'd2, 1, 1, 0);
        step(0, 0, 16'h0004, 0, 16'h0000, 4'd2, 1, 1, 0);
        step(0, 0, 16'h0004, 0, 16'h0000, 4'd2, 1, 0, 0);
        step(0, 0, 16'h0004, 0, 16'h0000, 4'd2, 1, 0, 0);
        step(0, 1, 16'h0004, 0, 16'h0000, 4'd2, 1, 0, 0);
        step(0, 1, 16'h0004, 0, 16'h0004, 4'd2, 1, 1, 0);
        step(0, 1, 16'h0000, 0, 16'h0004, 4'd2, 1, 1, 0);
        step(0, 1, 16'h0000, 0, 16'h0000, 4'd2, 1, 0, 0);

        // Reset mid-grant returns ptr to 0 (picks 0 over 1 afterwards)
        step(0, 1, 16'h0003, 0, 16'h0000, 4'd2, 1, 0, 0);
        step(0, 1, 16'h0003, 0, 16'h0001, 4'd0, 1, 1, 0);
        step(1, 1, 16'h0003, 0, 16'h0001, 4'd0, 1, 1, 0);
        step(0, 1, 16'h0003, 0, 16'h0000, 4'd0, 1, 0, 0);
        step(0, 1, 16'h0003, 0, 16'h0001, 4'd0, 1, 1, 0);
        step(0, 1, 16'h0003, 1, 16'h0001, 4'd0, 1, 1, 0);
        step(0, 1, 16'h0000, 0, 16'h0000, 4'd0, 1, 0, 0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", step_no, 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
